lsu_mem_stage: RTL and testbench
================================

Name: lsu_mem_stage

Overview:
- Memory-stage load/store unit sitting directly upstream of the byte-addressable data RAM and downstream of execute.
- Accepts one ALU result / memory op per handshake and converts RV32 funct3 into a word-aligned address, byte-select mask and lane-shifted write data for the RAM.
- Waits for the RAM's registered read response, then extracts and sign/zero-extends load data.
- Presents a registered valid/ready result to writeback.

Parameters:
- ADDR_W, 32, address and data width (fixed; RV32).
- RD_W, 5, destination register index width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i_vld  in  1  execute presents an op
- o_rdy  out  1  stage can accept op this cycle
- i_load  in  1  op is a load
- i_store  in  1  op is a store
- i_funct3  in  3  RV32 size/sign field
- i_addr  in  32  ALU result / effective address
- i_rs2_data  in  32  store data
- i_rd  in  5  destination register
- i_rd_wen  in  1  op writes rd
- o_dmem_wr_en  out  1  to RAM write enable
- o_dmem_sel  out  4  to RAM byte enables
- o_dmem_addr  out  32  to RAM word-aligned address
- o_dmem_addr_vld  out  1  to RAM request valid
- o_dmem_wdata  out  32  to RAM lane-shifted write data
- i_dmem_rdata  in  32  RAM read data
- i_dmem_d_valid  in  1  RAM response valid
- o_wb_vld  out  1  result valid to writeback
- i_wb_rdy  in  1  writeback accepts
- o_wb_data  out  32  result data
- o_wb_rd  out  5  destination register
- o_wb_wen  out  1  register write enable
- o_exc  out  1  exception flag on retired op
- o_exc_cause  out  2  exception cause: 01 misaligned load, 10 misaligned store, 11 illegal size

Behaviour:
- Reset (async, rst_n=0): state IDLE; every output register 0 (o_dmem_*, o_wb_*, o_exc*). o_rdy is combinational and reads 0 while reset is held.
- o_rdy = (state==IDLE) && (!o_wb_vld || i_wb_rdy).
- Accept occurs on an edge with i_vld && o_rdy.
- Output register drains on an edge with o_wb_vld && i_wb_rdy.
- While o_wb_vld=1 && i_wb_rdy=0, all o_wb_* and o_exc* hold stable.
- FSM states: IDLE, ACCESS, WAIT.
- IDLE, non-memory op accepted: o_wb_data=i_addr, o_wb_rd=i_rd, o_wb_wen=i_rd_wen && (i_rd!=0), o_wb_vld=1 on next edge. State stays IDLE; throughput 1 op/cycle.
- IDLE, load/store accepted: register o_dmem_addr={i_addr[31:2],2'b00}, sel, wdata, wr_en=i_store, o_dmem_addr_vld=1. Go to ACCESS.
- Accepted on edge N: addr_vld is high exactly for cycle N..N+1. On edge N+1 addr_vld drops and state goes to WAIT.
- WAIT: on the edge where i_dmem_d_valid=1 (nominally N+2), capture result, set o_wb_vld=1, go to IDLE.
- Loads retire with extracted data; wen = i_rd_wen && rd!=0.
- Stores retire with wen=0, data=0.
- Store sel/wdata by funct3 and offset o=i_addr[1:0]:
  - SB: sel=0001<<o, wdata=rs2[7:0] replicated to all four lanes.
  - SH: sel=0011<<o, wdata={2{rs2[15:0]}}.
  - SW: sel=1111, wdata=rs2.
- Load extraction from i_dmem_rdata by registered offset:
  - LB/LBU: byte o, sign-/zero-extended.
  - LH/LHU: half o[1], sign-/zero-extended.
  - LW: whole word.
- Illegal size: load funct3 011/110/111, store funct3 1xx, or i_load&&i_store both high.
  - No RAM access; retire on next edge with wen=0, o_exc=1, cause 11.
- Misaligned access: half with o[0]=1, or word with o!=0. Handling per optional feature.
- Reset asserted during ACCESS/WAIT: immediate return to IDLE, addr_vld=0, and the in-flight op is discarded. The RAM itself gates on rst_n, so no partial write occurs.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: a misaligned op makes no RAM access and retires on the next edge with wen=0, o_exc=1, cause 01 (load) / 10 (store).
- Undefined: misaligned offset bits are forced to zero (half clears o[0], word clears o[1:0]), the access proceeds normally, and o_exc is tied 0.

Decomposition:
- Shared header lsu_defs.vh holds:
  - funct3 localparams (LB..LHU, SB..SW)
  - FSM state encoding
  - exception cause codes
- One natural sub-module: lsu_load_align, purely combinational; inputs rdata, offset, funct3; output extended 32-bit word. It is reused by any future cache path.

Test Plan:
- SW 0xCAFEBABE to DATA_START+0x10, then LW same address -> sel=1111, addr=+0x10; load o_wb_data=0xCAFEBABE with o_wb_vld rising on edge N+2.
- SB rs2=0x000000A5 to +0x13 -> sel=1000, wdata=0xA5A5A5A5, addr=+0x10. Then LB +0x13 -> 0xFFFFFFA5; LBU -> 0x000000A5.
- SH rs2=0x8001 to +0x12 -> sel=1100, wdata=0x80018001. Then LH +0x12 -> 0xFFFF8001; LHU -> 0x00008001.
- LW +0x11:
  - Macro defined: addr_vld never asserts, o_exc=1, cause=01, wen=0.
  - Macro undefined: RAM address +0x10, data of that word.
- Hold i_wb_rdy=0 after a load completes -> o_wb_vld=1, data stable, o_rdy=0, a following i_vld is not accepted. Releasing rdy drains, and the next op is accepted that edge.
- Assert rst_n=0 during WAIT -> all outputs 0 without a clock edge. After release, LW +0x10 returns the stored word.

Source files
------------

// File: rtl/lsu_mem_stage_pkg.sv
// Shared LSU definitions: RV32 funct3 sizes, FSM encoding and exception causes.
// Pure declarations; no logic or timing.
package lsu_mem_stage_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_MIS_LD  = 2'b01;
  localparam logic [1:0] CAUSE_MIS_ST  = 2'b10;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_WAIT   = 2'b10
  } state_t;

endpackage

// File: rtl/lsu_load_align.sv
// Extracts and sign/zero-extends load data from a RAM word by byte offset and funct3.
// Purely combinational, no backpressure; shared with any future cache read path.
module lsu_load_align
  import lsu_mem_stage_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'h00;
    case (offset_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    data_o = rdata_i;
    case (funct3_i)
      F3_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  data_o = {24'h0, byte_sel};
      F3_LH:   data_o = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  data_o = {16'h0, half_sel};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// RV32 memory-stage LSU: non-mem ops retire next edge; loads/stores retire on the RAM response edge (nominally +2).
// o_rdy stalls while an access is in flight or the writeback register is held; LSU_MISALIGN_TRAP_EN makes misalignment trap.
module lsu_mem_stage
  import lsu_mem_stage_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int RD_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_vld,
  output logic              o_rdy,
  input  logic              i_load,
  input  logic              i_store,
  input  logic [2:0]        i_funct3,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [ADDR_W-1:0] i_rs2_data,
  input  logic [RD_W-1:0]   i_rd,
  input  logic              i_rd_wen,
  output logic              o_dmem_wr_en,
  output logic [3:0]        o_dmem_sel,
  output logic [ADDR_W-1:0] o_dmem_addr,
  output logic              o_dmem_addr_vld,
  output logic [ADDR_W-1:0] o_dmem_wdata,
  input  logic [ADDR_W-1:0] i_dmem_rdata,
  input  logic              i_dmem_d_valid,
  output logic              o_wb_vld,
  input  logic              i_wb_rdy,
  output logic [ADDR_W-1:0] o_wb_data,
  output logic [RD_W-1:0]   o_wb_rd,
  output logic              o_wb_wen,
  output logic              o_exc,
  output logic [1:0]        o_exc_cause
);

  state_t            state_q;
  logic              dmem_wr_en_q, dmem_addr_vld_q;
  logic [3:0]        dmem_sel_q;
  logic [ADDR_W-1:0] dmem_addr_q, dmem_wdata_q;
  logic              wb_vld_q, wb_wen_q, exc_q;
  logic [ADDR_W-1:0] wb_data_q;
  logic [RD_W-1:0]   wb_rd_q;
  logic [1:0]        exc_cause_q;
  logic [2:0]        ld_f3_q;
  logic [1:0]        ld_off_q;
  logic              ld_q, pend_wen_q;
  logic [RD_W-1:0]   pend_rd_q;

  logic              accept, is_mem, illegal, trap;
  logic [1:0]        size, off_raw, off_eff;
  logic [3:0]        sel_d;
  logic [ADDR_W-1:0] wdata_d, load_data;

  assign o_rdy  = rst_n && (state_q == ST_IDLE) && (!wb_vld_q || i_wb_rdy);
  assign accept = i_vld && o_rdy;

  assign size    = i_funct3[1:0];
  assign off_raw = i_addr[1:0];
  assign is_mem  = i_load || i_store;
  // Store size 11 (SD) has no RV32 lane mapping, so it is rejected with the 1xx encodings.
  assign illegal = (i_load && i_store)
                || (i_load && (i_funct3 == 3'b011 || i_funct3 == 3'b110 || i_funct3 == 3'b111))
                || (i_store && (i_funct3[2] || size == 2'b11));

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap    = (size == SZ_HALF && off_raw[0]) || (size == SZ_WORD && off_raw != 2'b00);
  assign off_eff = off_raw;
`else
  assign trap    = 1'b0;
  assign off_eff = (size == SZ_WORD) ? 2'b00 :
                   (size == SZ_HALF) ? {off_raw[1], 1'b0} : off_raw;
`endif

  always_comb begin
    sel_d   = 4'b1111;
    wdata_d = i_rs2_data;
    case (size)
      SZ_BYTE: begin
        sel_d   = 4'b0001 << off_eff;
        wdata_d = {4{i_rs2_data[7:0]}};
      end
      SZ_HALF: begin
        sel_d   = 4'b0011 << off_eff;
        wdata_d = {2{i_rs2_data[15:0]}};
      end
      default: ;
    endcase
  end

  lsu_load_align u_load_align (
    .rdata_i  (i_dmem_rdata),
    .offset_i (ld_off_q),
    .funct3_i (ld_f3_q),
    .data_o   (load_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      dmem_wr_en_q    <= 1'b0;
      dmem_addr_vld_q <= 1'b0;
      dmem_sel_q      <= '0;
      dmem_addr_q     <= '0;
      dmem_wdata_q    <= '0;
      wb_vld_q        <= 1'b0;
      wb_wen_q        <= 1'b0;
      wb_data_q       <= '0;
      wb_rd_q         <= '0;
      exc_q           <= 1'b0;
      exc_cause_q     <= CAUSE_NONE;
      ld_f3_q         <= '0;
      ld_off_q        <= '0;
      ld_q            <= 1'b0;
      pend_wen_q      <= 1'b0;
      pend_rd_q       <= '0;
    end else begin
      if (wb_vld_q && i_wb_rdy) wb_vld_q <= 1'b0;
      case (state_q)
        ST_IDLE: if (accept) begin
          if (!is_mem) begin
            wb_vld_q    <= 1'b1;
            wb_data_q   <= i_addr;
            wb_rd_q     <= i_rd;
            wb_wen_q    <= i_rd_wen && (i_rd != '0);
            exc_q       <= 1'b0;
            exc_cause_q <= CAUSE_NONE;
          end else if (illegal || trap) begin
            wb_vld_q    <= 1'b1;
            wb_data_q   <= '0;
            wb_rd_q     <= i_rd;
            wb_wen_q    <= 1'b0;
            exc_q       <= 1'b1;
            exc_cause_q <= illegal ? CAUSE_ILLEGAL : (i_load ? CAUSE_MIS_LD : CAUSE_MIS_ST);
          end else begin
            dmem_addr_q     <= {i_addr[ADDR_W-1:2], 2'b00};
            dmem_sel_q      <= sel_d;
            dmem_wdata_q    <= wdata_d;
            dmem_wr_en_q    <= i_store;
            dmem_addr_vld_q <= 1'b1;
            ld_f3_q         <= i_funct3;
            ld_off_q        <= off_eff;
            ld_q            <= i_load;
            pend_rd_q       <= i_rd;
            pend_wen_q      <= i_rd_wen && (i_rd != '0);
            state_q         <= ST_ACCESS;
          end
        end
        // The request is a single-cycle pulse; wr_en drops with it so the RAM never sees a stale write.
        ST_ACCESS: begin
          dmem_addr_vld_q <= 1'b0;
          dmem_wr_en_q    <= 1'b0;
          state_q         <= ST_WAIT;
        end
        ST_WAIT: if (i_dmem_d_valid) begin
          wb_vld_q    <= 1'b1;
          wb_data_q   <= ld_q ? load_data : '0;
          wb_rd_q     <= pend_rd_q;
          wb_wen_q    <= ld_q && pend_wen_q;
          exc_q       <= 1'b0;
          exc_cause_q <= CAUSE_NONE;
          state_q     <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_dmem_wr_en    = dmem_wr_en_q;
  assign o_dmem_sel      = dmem_sel_q;
  assign o_dmem_addr     = dmem_addr_q;
  assign o_dmem_addr_vld = dmem_addr_vld_q;
  assign o_dmem_wdata    = dmem_wdata_q;
  assign o_wb_vld        = wb_vld_q;
  assign o_wb_data       = wb_data_q;
  assign o_wb_rd         = wb_rd_q;
  assign o_wb_wen        = wb_wen_q;
  assign o_exc           = exc_q;
  assign o_exc_cause     = exc_cause_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage against a small registered byte-enable RAM model.
// Expected values are hand-computed from the stimulus.
module tb_lsu_mem_stage;

  localparam logic [31:0] DS = 32'h0000_0100;

  logic        clk, rst_n;
  logic        i_vld, o_rdy, i_load, i_store, i_rd_wen;
  logic [2:0]  i_funct3;
  logic [31:0] i_addr, i_rs2_data;
  logic [4:0]  i_rd;
  logic        o_dmem_wr_en, o_dmem_addr_vld;
  logic [3:0]  o_dmem_sel;
  logic [31:0] o_dmem_addr, o_dmem_wdata, i_dmem_rdata;
  logic        i_dmem_d_valid;
  logic        o_wb_vld, i_wb_rdy, o_wb_wen, o_exc;
  logic [31:0] o_wb_data;
  logic [4:0]  o_wb_rd;
  logic [1:0]  o_exc_cause;

  int n_chk = 0;
  int n_err = 0;

  lsu_mem_stage dut (
    .clk(clk), .rst_n(rst_n), .i_vld(i_vld), .o_rdy(o_rdy),
    .i_load(i_load), .i_store(i_store), .i_funct3(i_funct3),
    .i_addr(i_addr), .i_rs2_data(i_rs2_data), .i_rd(i_rd), .i_rd_wen(i_rd_wen),
    .o_dmem_wr_en(o_dmem_wr_en), .o_dmem_sel(o_dmem_sel), .o_dmem_addr(o_dmem_addr),
    .o_dmem_addr_vld(o_dmem_addr_vld), .o_dmem_wdata(o_dmem_wdata),
    .i_dmem_rdata(i_dmem_rdata), .i_dmem_d_valid(i_dmem_d_valid),
    .o_wb_vld(o_wb_vld), .i_wb_rdy(i_wb_rdy), .o_wb_data(o_wb_data),
    .o_wb_rd(o_wb_rd), .o_wb_wen(o_wb_wen), .o_exc(o_exc), .o_exc_cause(o_exc_cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered RAM: request sampled on an edge, response valid for the following cycle.
  logic [31:0] mem [64];
  initial for (int k = 0; k < 64; k++) mem[k] = 32'h0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_dmem_d_valid <= 1'b0;
      i_dmem_rdata   <= 32'h0;
    end else begin
      i_dmem_d_valid <= o_dmem_addr_vld;
      if (o_dmem_addr_vld) begin
        i_dmem_rdata <= mem[o_dmem_addr[7:2]];
        if (o_dmem_wr_en)
          for (int b = 0; b < 4; b++)
            if (o_dmem_sel[b]) mem[o_dmem_addr[7:2]][8*b +: 8] <= o_dmem_wdata[8*b +: 8];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] rs2, input logic [4:0] rd);
    i_vld = 1'b1; i_load = ld; i_store = st; i_funct3 = f3;
    i_addr = addr; i_rs2_data = rs2; i_rd = rd; i_rd_wen = 1'b1;
  endtask

  // Memory op through ACCESS/WAIT: checks the RAM request and the N+2 retirement.
  task automatic mem_op(input string tag, input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] rs2, input logic [4:0] rd,
                        input logic [3:0] exp_sel, input logic [31:0] exp_wdata,
                        input logic [31:0] exp_data, input logic exp_wen);
    drive(ld, st, f3, addr, rs2, rd);
    check({tag, ".rdy"}, {31'h0, o_rdy}, 32'd1);
    step();
    i_vld = 1'b0;
    check({tag, ".avld"}, {31'h0, o_dmem_addr_vld}, 32'd1);
    check({tag, ".addr"}, o_dmem_addr, {addr[31:2], 2'b00});
    check({tag, ".sel"}, {28'h0, o_dmem_sel}, {28'h0, exp_sel});
    check({tag, ".wr"}, {31'h0, o_dmem_wr_en}, {31'h0, st});
    if (st) check({tag, ".wdata"}, o_dmem_wdata, exp_wdata);
    step();
    check({tag, ".avld_drop"}, {31'h0, o_dmem_addr_vld}, 32'd0);
    check({tag, ".wb_early"}, {31'h0, o_wb_vld}, 32'd0);
    step();
    check({tag, ".wb_vld"}, {31'h0, o_wb_vld}, 32'd1);
    check({tag, ".data"}, o_wb_data, exp_data);
    check({tag, ".wen"}, {31'h0, o_wb_wen}, {31'h0, exp_wen});
    check({tag, ".exc"}, {31'h0, o_exc}, 32'd0);
  endtask

  // Single-edge op (non-memory or exception): retires on the accept edge.
  task automatic imm_op(input string tag, input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [4:0] rd,
                        input logic [31:0] exp_data, input logic exp_wen,
                        input logic exp_exc, input logic [1:0] exp_cause);
    drive(ld, st, f3, addr, 32'h0, rd);
    step();
    i_vld = 1'b0;
    check({tag, ".wb_vld"}, {31'h0, o_wb_vld}, 32'd1);
    check({tag, ".data"}, o_wb_data, exp_data);
    check({tag, ".rd"}, {27'h0, o_wb_rd}, {27'h0, rd});
    check({tag, ".wen"}, {31'h0, o_wb_wen}, {31'h0, exp_wen});
    check({tag, ".exc"}, {31'h0, o_exc}, {31'h0, exp_exc});
    check({tag, ".cause"}, {30'h0, o_exc_cause}, {30'h0, exp_cause});
    check({tag, ".avld"}, {31'h0, o_dmem_addr_vld}, 32'd0);
    check({tag, ".rdy"}, {31'h0, o_rdy}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; i_vld = 1'b0; i_load = 1'b0; i_store = 1'b0; i_funct3 = 3'b0;
    i_addr = 32'h0; i_rs2_data = 32'h0; i_rd = 5'd0; i_rd_wen = 1'b0; i_wb_rdy = 1'b1;
    #1;
    check("rst.rdy", {31'h0, o_rdy}, 32'd0);
    check("rst.wb_vld", {31'h0, o_wb_vld}, 32'd0);
    check("rst.avld", {31'h0, o_dmem_addr_vld}, 32'd0);
    check("rst.exc", {31'h0, o_exc}, 32'd0);
    step(); step();
    rst_n = 1'b1;
    #1;
    check("rst_rel.rdy", {31'h0, o_rdy}, 32'd1);

    // Back-to-back non-memory ops, including rd=0 suppressing the write.
    imm_op("alu1", 1'b0, 1'b0, 3'b000, 32'h1234_5678, 5'd7, 32'h1234_5678, 1'b1, 1'b0, 2'b00);
    imm_op("alu0", 1'b0, 1'b0, 3'b000, 32'h0BAD_F00D, 5'd0, 32'h0BAD_F00D, 1'b0, 1'b0, 2'b00);
    step();

    mem_op("sw",  1'b0, 1'b1, 3'b010, DS + 32'h10, 32'hCAFE_BABE, 5'd4, 4'b1111, 32'hCAFE_BABE, 32'h0, 1'b0);
    mem_op("lw",  1'b1, 1'b0, 3'b010, DS + 32'h10, 32'h0, 5'd5, 4'b1111, 32'h0, 32'hCAFE_BABE, 1'b1);
    mem_op("sb",  1'b0, 1'b1, 3'b000, DS + 32'h13, 32'h0000_00A5, 5'd4, 4'b1000, 32'hA5A5_A5A5, 32'h0, 1'b0);
    mem_op("lb",  1'b1, 1'b0, 3'b000, DS + 32'h13, 32'h0, 5'd6, 4'b1000, 32'h0, 32'hFFFF_FFA5, 1'b1);
    mem_op("lbu", 1'b1, 1'b0, 3'b100, DS + 32'h13, 32'h0, 5'd6, 4'b1000, 32'h0, 32'h0000_00A5, 1'b1);
    mem_op("sh",  1'b0, 1'b1, 3'b001, DS + 32'h12, 32'h0000_8001, 5'd4, 4'b1100, 32'h8001_8001, 32'h0, 1'b0);
    mem_op("lh",  1'b1, 1'b0, 3'b001, DS + 32'h12, 32'h0, 5'd8, 4'b1100, 32'h0, 32'hFFFF_8001, 1'b1);
    mem_op("lhu", 1'b1, 1'b0, 3'b101, DS + 32'h12, 32'h0, 5'd8, 4'b1100, 32'h0, 32'h0000_8001, 1'b1);
    mem_op("lb0", 1'b1, 1'b0, 3'b000, DS + 32'h10, 32'h0, 5'd8, 4'b0001, 32'h0, 32'hFFFF_FFBE, 1'b1);

`ifdef LSU_MISALIGN_TRAP_EN
    imm_op("lw_mis", 1'b1, 1'b0, 3'b010, DS + 32'h11, 5'd9, 32'h0, 1'b0, 1'b1, 2'b01);
    imm_op("sw_mis", 1'b0, 1'b1, 3'b010, DS + 32'h12, 5'd9, 32'h0, 1'b0, 1'b1, 2'b10);
`else
    mem_op("lw_mis", 1'b1, 1'b0, 3'b010, DS + 32'h11, 32'h0, 5'd9, 4'b1111, 32'h0, 32'h8001_BABE, 1'b1);
    mem_op("lh_mis", 1'b1, 1'b0, 3'b001, DS + 32'h13, 32'h0, 5'd9, 4'b1100, 32'h0, 32'hFFFF_8001, 1'b1);
`endif
    step();
    imm_op("ld_ill", 1'b1, 1'b0, 3'b011, DS + 32'h10, 5'd10, 32'h0, 1'b0, 1'b1, 2'b11);
    imm_op("st_ill", 1'b0, 1'b1, 3'b100, DS + 32'h10, 5'd10, 32'h0, 1'b0, 1'b1, 2'b11);
    imm_op("ldst",   1'b1, 1'b1, 3'b010, DS + 32'h10, 5'd10, 32'h0, 1'b0, 1'b1, 2'b11);
    step();

    // Writeback backpressure: result holds, next op waits, accepted on the draining edge.
    i_wb_rdy = 1'b0;
    mem_op("lw_bp", 1'b1, 1'b0, 3'b010, DS + 32'h10, 32'h0, 5'd11, 4'b1111, 32'h0, 32'h8001_BABE, 1'b1);
    drive(1'b0, 1'b0, 3'b000, 32'hDEAD_0001, 32'h0, 5'd3);
    #1;
    check("bp.rdy0", {31'h0, o_rdy}, 32'd0);
    for (int c = 0; c < 3; c++) begin
      step();
      check("bp.hold_vld", {31'h0, o_wb_vld}, 32'd1);
      check("bp.hold_data", o_wb_data, 32'h8001_BABE);
      check("bp.hold_rd", {27'h0, o_wb_rd}, 32'd11);
      check("bp.hold_rdy", {31'h0, o_rdy}, 32'd0);
    end
    i_wb_rdy = 1'b1;
    #1;
    check("bp.rdy1", {31'h0, o_rdy}, 32'd1);
    step();
    i_vld = 1'b0;
    check("bp.next_vld", {31'h0, o_wb_vld}, 32'd1);
    check("bp.next_data", o_wb_data, 32'hDEAD_0001);
    check("bp.next_rd", {27'h0, o_wb_rd}, 32'd3);
    step();
    check("bp.drained", {31'h0, o_wb_vld}, 32'd0);

    // Reset while WAITing for the RAM: everything clears without a clock edge.
    drive(1'b1, 1'b0, 3'b010, DS + 32'h10, 32'h0, 5'd12);
    step();
    i_vld = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    check("rstw.avld", {31'h0, o_dmem_addr_vld}, 32'd0);
    check("rstw.addr", o_dmem_addr, 32'h0);
    check("rstw.sel", {28'h0, o_dmem_sel}, 32'h0);
    check("rstw.wb_vld", {31'h0, o_wb_vld}, 32'd0);
    check("rstw.data", o_wb_data, 32'h0);
    check("rstw.rdy", {31'h0, o_rdy}, 32'd0);
    step();
    check("rstw.no_retire", {31'h0, o_wb_vld}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    mem_op("lw_post", 1'b1, 1'b0, 3'b010, DS + 32'h10, 32'h0, 5'd13, 4'b1111, 32'h0, 32'h8001_BABE, 1'b1);
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
